// File: rtl/fft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared definitions for the FFT frame controller: FSM state encoding,
// error-flag bit positions and default geometry of the frame.
// ---------------------------------------------------------------------------
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    // Positions inside the sticky err vector
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_SPURIOUS = 1;

    localparam int DEF_N       = 32;
    localparam int DEF_W       = 16;
    localparam int DEF_TIMEOUT = 1024;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/fft_ctrl_cnt.sv
// ---------------------------------------------------------------------------
// fft_ctrl_cnt
// Generic up-counter with synchronous clear, count enable and a terminal
// flag that is high while the count equals TERM.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear (wins over en)
//   en   - increment by one
//   cnt  - current count
//   tc   - high while cnt == TERM
// ---------------------------------------------------------------------------
module fft_ctrl_cnt #(
    parameter int WIDTH = 4,
    parameter int TERM  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
    assign tc  = (r_cnt == TERM_V);

endmodule

// File: rtl/fft32_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft32_frame_ctrl
// Frame sequencer in front of an N-point FFT core. Loads exactly N accepted
// samples into the core, waits for the core's result burst, and re-times the
// N results into an indexed stream with a last marker. Supervises the core
// with a WAIT timeout and flags done pulses that arrive outside a frame.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready/in_re/in_im - upstream sample stream
//   core_we/core_in_re/core_in_im - write port of the FFT core
//   core_done/core_out_re/_im     - result port of the FFT core
//   out_valid/out_re/out_im       - result stream
//   out_index/out_last            - bin index, high on the Nth result
//   busy                          - high outside IDLE
//   frame_cnt                     - completed frames (wraps)
//   err                           - sticky: bit0 timeout, bit1 spurious done
//   clr_err                       - clears err (a same-cycle new error wins)
// ---------------------------------------------------------------------------
module fft32_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_re,
    input  logic [W-1:0]         in_im,
    output logic                 core_we,
    output logic [W-1:0]         core_in_re,
    output logic [W-1:0]         core_in_im,
    input  logic                 core_done,
    input  logic [W-1:0]         core_out_re,
    input  logic [W-1:0]         core_out_im,
    output logic                 out_valid,
    output logic [W-1:0]         out_re,
    output logic [W-1:0]         out_im,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [1:0]           err,
    input  logic                 clr_err
);

    localparam int IDX_W  = $clog2(N);
    localparam int WAIT_W = $clog2(TIMEOUT);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_core_we;
    logic [W-1:0]       r_core_in_re, r_core_in_im;
    logic               r_out_valid, r_out_last;
    logic [W-1:0]       r_out_re, r_out_im;
    logic [IDX_W-1:0]   r_out_index;
    logic               r_busy;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [1:0]         r_err;

    logic               w_accept, w_capture, w_timeout, w_spurious;
    logic               w_load_done, w_frame_done;
    logic               w_load_tc, w_wait_tc, w_unload_tc;
    logic [IDX_W-1:0]   w_load_cnt, w_unload_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt;
    logic [1:0]         w_err_set;
    logic               w_unused_cnt;

    assign w_accept     = in_valid && r_in_ready;
    // Results are only meaningful once all N samples have gone to the core
    assign w_capture    = core_done && (r_state == ST_WAIT || r_state == ST_UNLOAD);
    assign w_spurious   = core_done && (r_state == ST_IDLE || r_state == ST_LOAD);
    assign w_timeout    = (r_state == ST_WAIT) && !core_done && w_wait_tc;
    assign w_load_done  = (r_state == ST_LOAD) && w_accept && w_load_tc;
    assign w_frame_done = (r_state == ST_UNLOAD) && core_done && w_unload_tc;

    // Only the terminal flags steer the FSM; the load/wait counts are not needed
    assign w_unused_cnt = ^{w_load_cnt, w_wait_cnt};

    always_comb begin
        w_err_set               = '0;
        w_err_set[ERR_TIMEOUT]  = w_timeout;
        w_err_set[ERR_SPURIOUS] = w_spurious;
    end

    // Samples accepted in this frame; terminal at the Nth sample
    fft_ctrl_cnt #(.WIDTH(IDX_W), .TERM(N - 1)) u_load_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_load_done),
        .en  (w_accept),
        .cnt (w_load_cnt),
        .tc  (w_load_tc)
    );

    // Cycles spent in WAIT; held at zero outside it
    fft_ctrl_cnt #(.WIDTH(WAIT_W), .TERM(TIMEOUT - 1)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr ((r_state != ST_WAIT) || core_done || w_timeout),
        .en  (r_state == ST_WAIT),
        .cnt (w_wait_cnt),
        .tc  (w_wait_tc)
    );

    // Results delivered in this frame; doubles as out_index
    fft_ctrl_cnt #(.WIDTH(IDX_W), .TERM(N - 1)) u_unload_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_frame_done),
        .en  (w_capture),
        .cnt (w_unload_cnt),
        .tc  (w_unload_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_core_we    <= 1'b0;
            r_core_in_re <= '0;
            r_core_in_im <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_re     <= '0;
            r_out_im     <= '0;
            r_out_index  <= '0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= '0;
            r_err        <= '0;
        end else begin
            // in_ready is low outside IDLE/LOAD, so accepts only happen there
            r_core_we <= w_accept;
            if (w_accept) begin
                r_core_in_re <= in_re;
                r_core_in_im <= in_im;
            end

            r_out_valid <= w_capture;
            r_out_last  <= w_frame_done;
            if (w_capture) begin
                r_out_re    <= core_out_re;
                r_out_im    <= core_out_im;
                r_out_index <= w_unload_cnt;
            end

            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            // A new error in the clearing cycle survives the clear
            r_err <= (clr_err ? 2'b00 : r_err) | w_err_set;

            case (r_state)
                ST_IDLE: begin
                    // Rises one cycle after entering IDLE, keeping frames apart
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_load_done) begin
                        r_state    <= ST_WAIT;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (core_done) begin
                        r_state <= ST_UNLOAD;
                    end else if (w_wait_tc) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_UNLOAD: begin
                    if (w_frame_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign core_we    = r_core_we;
    assign core_in_re = r_core_in_re;
    assign core_in_im = r_core_in_im;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_re     = r_out_re;
    assign out_im     = r_out_im;
    assign out_index  = r_out_index;
    assign busy       = r_busy;
    assign frame_cnt  = r_frame_cnt;
    assign err        = r_err;

endmodule

// File: tb/tb_fft32_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft32_frame_ctrl
// Self-checking bench: randomized frames against a count-based behavioural
// model, compared on every cycle, plus literal expectations for reset,
// frame counting, timeout, spurious done and the wrap of a 2-bit frame_cnt.
// ---------------------------------------------------------------------------
module tb_fft32_frame_ctrl;

    localparam int N       = 32;
    localparam int W       = 16;
    localparam int TIMEOUT = 100;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = $clog2(N);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_re = '0, in_im = '0;
    logic             core_we;
    logic [W-1:0]     core_in_re, core_in_im;
    logic             core_done = 1'b0;
    logic [W-1:0]     core_out_re = '0, core_out_im = '0;
    logic             out_valid;
    logic [W-1:0]     out_re, out_im;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic [1:0]       err;
    logic             clr_err = 1'b0;

    always #5 clk = ~clk;

    fft32_frame_ctrl #(.N(N), .W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .core_we     (core_we),
        .core_in_re  (core_in_re),
        .core_in_im  (core_in_im),
        .core_done   (core_done),
        .core_out_re (core_out_re),
        .core_out_im (core_out_im),
        .out_valid   (out_valid),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .err         (err),
        .clr_err     (clr_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The frame is described only by how many samples went in (m_loaded) and
    // how many results came out (m_results); every output follows from them.
    int               m_loaded, m_results, m_wait;
    bit               model_ready = 1'b0;
    bit               m_acc, m_cap, m_spur, m_tmo;
    logic             exp_in_ready, exp_core_we, exp_out_valid, exp_out_last, exp_busy;
    logic [W-1:0]     exp_cre, exp_cim, exp_ore, exp_oim;
    logic [IDX_W-1:0] exp_idx;
    logic [CNT_W-1:0] exp_fc;
    logic [1:0]       exp_err;

    always @(posedge clk) begin
        if (rst) begin
            m_loaded = 0; m_results = 0; m_wait = 0;
            exp_in_ready = 0; exp_core_we = 0; exp_out_valid = 0; exp_out_last = 0;
            exp_busy = 0; exp_cre = '0; exp_cim = '0; exp_ore = '0; exp_oim = '0;
            exp_idx = '0; exp_fc = '0; exp_err = '0;
            model_ready = 1'b1;
        end else begin
            m_acc  = in_valid && exp_in_ready;
            m_cap  = core_done && (m_loaded == N);
            m_spur = core_done && (m_loaded < N);
            m_tmo  = (m_loaded == N) && (m_results == 0) && !core_done && (m_wait == TIMEOUT - 1);

            exp_core_we = m_acc;
            if (m_acc) begin exp_cre = in_re; exp_cim = in_im; end
            exp_out_valid = m_cap;
            exp_out_last  = m_cap && (m_results == N - 1);
            if (m_cap) begin
                exp_ore = core_out_re; exp_oim = core_out_im;
                exp_idx = IDX_W'(m_results);
            end
            exp_err      = (clr_err ? 2'b00 : exp_err) | {m_spur, m_tmo};
            exp_in_ready = (m_loaded < N) && (m_loaded + int'(m_acc) < N);

            if (m_loaded < N) begin
                m_loaded += int'(m_acc);
                m_wait = 0;
            end else if (m_cap) begin
                m_results++;
                if (m_results == N) begin
                    m_loaded = 0; m_results = 0; exp_fc++;
                end
            end else if (m_results == 0) begin
                if (m_tmo) begin m_loaded = 0; m_wait = 0; end
                else m_wait++;
            end
            exp_busy = (m_loaded != 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    int we_cnt = 0, out_cnt = 0;
    int last_idx = -1;

    always @(negedge clk) begin
        if (model_ready) begin
            check("in_ready", in_ready, exp_in_ready);
            check("core_we", core_we, exp_core_we);
            if (exp_core_we) begin
                check("core_in_re", core_in_re, exp_cre);
                check("core_in_im", core_in_im, exp_cim);
            end
            check("out_valid", out_valid, exp_out_valid);
            check("out_last", out_last, exp_out_last);
            if (exp_out_valid) begin
                check("out_re", out_re, exp_ore);
                check("out_im", out_im, exp_oim);
                check("out_index", out_index, exp_idx);
            end
            check("busy", busy, exp_busy);
            check("frame_cnt", frame_cnt, exp_fc);
            check("err", err, exp_err);
            if (core_we) we_cnt++;
            if (out_valid) out_cnt++;
            if (out_last) last_idx = int'(out_index);
        end
    end

    // ---------------- stimulus ----------------
    // Offers samples re=k, im=-k until `count` have been accepted.
    task automatic load_frame(input int valid_pct, input bit alternate, input int count);
        int k = 0;
        int guard = 0;
        while (k < count && guard < 4000) begin
            @(negedge clk);
            in_valid = alternate ? (guard % 2 == 0) : (int'($urandom_range(0, 99)) < valid_pct);
            in_re = W'(k);
            in_im = W'(-k);
            if (in_valid && in_ready) k++;
            guard++;
        end
        check("load_progress", k, count);
    endtask

    // Core stand-in: after `lat` cycles returns N results re=100+i.
    task automatic unload_frame(input int lat, input bit hold, input int gap_at,
                                input int gap_len, input bit rand_gaps);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            in_valid  = hold;
            core_done = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            int g;
            g = (i == gap_at) ? gap_len : (rand_gaps ? int'($urandom_range(0, 2)) : 0);
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                core_done = 1'b0;
            end
            @(negedge clk);
            core_done   = 1'b1;
            core_out_re = W'(100 + i);
            core_out_im = W'($urandom);
        end
        @(negedge clk);
        core_done = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic run_frame(input int valid_pct, input bit alternate, input bit hold,
                             input int lat, input int gap_at, input int gap_len,
                             input bit rand_gaps);
        we_cnt   = 0;
        out_cnt  = 0;
        last_idx = -1;
        load_frame(valid_pct, alternate, N);
        unload_frame(lat, hold, gap_at, gap_len, rand_gaps);
        @(negedge clk);
        check("frame_we_pulses", we_cnt, N);
        check("frame_results", out_cnt, N);
        check("frame_last_index", last_idx, N - 1);
    endtask

    initial begin
        int guard;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_core_we", core_we, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // Back-to-back frame, in_valid held through WAIT/UNLOAD
        run_frame(100, 1'b0, 1'b1, 40, -1, 0, 1'b0);
        check("b2b_frame_cnt", frame_cnt, 1);
        check("b2b_err", err, 0);

        // Gapped input and a 3-cycle result gap at index 10
        run_frame(100, 1'b1, 1'b0, 5, 10, 3, 1'b0);
        check("gap_frame_cnt", frame_cnt, 2);

        // Timeout: core never answers
        load_frame(70, 1'b0, N);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (busy && guard < TIMEOUT + 20) begin
            @(negedge clk);
            guard++;
        end
        check("timeout_busy", busy, 0);
        check("timeout_err", err, 2'b01);
        @(negedge clk);
        check("timeout_in_ready", in_ready, 1);
        check("timeout_frame_cnt", frame_cnt, 2);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("timeout_clr", err, 2'b00);

        // Spurious done in IDLE, then clear colliding with a new spurious pulse
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("spur_err", err, 2'b10);
        check("spur_out_valid", out_valid, 0);
        core_done = 1'b1;
        clr_err   = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        clr_err   = 1'b0;
        check("spur_set_wins", err, 2'b10);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("spur_clr", err, 2'b00);

        // Reset after 17 samples
        load_frame(80, 1'b0, 17);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_core_we", core_we, 0);
        check("mid_rst_core_in_re", core_in_re, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_re", out_re, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        in_valid = 1'b0;

        // Five random frames; 2-bit frame_cnt runs 1,2,3,0,1
        for (int f = 0; f < 5; f++) begin
            run_frame(int'($urandom_range(30, 100)), 1'b0, 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 20)), -1, 0, 1'b1);
            check("wrap_frame_cnt", frame_cnt, (f + 1) % 4);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
